i2s_dsp_rx_frame_sync: RTL and testbench

Slave-side DSP-mode receiver front end: detects the single-cycle frame-sync pulse on the WS line driven by the DSP WS generator, then deserializes the serial data line into `(cfg_num_bits_i+1)`-bit words, `(cfg_num_words_i+1)` words per frame. It sits between the I2S pads and the RX uDMA FIFO and hands words out on a valid/ready interface with a one-word holding register. It also reports frame-sync errors and overflow.

---
 rtl/i2s_dsp_rx_frame_sync.sv | 163 ++++++++++++++++
 tb/tb_i2s_dsp_rx_frame_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dsp_rx_frame_sync.sv
// DSP-mode serial receiver: frame-sync pulse detect, word deserializer,
// single-word holding register with overflow and sync-error reporting.
module i2s_dsp_rx_frame_sync (
  input  logic        sck_i,
  input  logic        rstn_i,
  input  logic        cfg_en_i,
  input  logic [4:0]  cfg_num_bits_i,
  input  logic [2:0]  cfg_num_words_i,
  input  logic        cfg_dsp_delay_i,
  input  logic        cfg_lsb_first_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [31:0] data_o,
  output logic [2:0]  word_idx_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        frame_err_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA
  } state_e;

  state_e      state_q, state_d;
  logic        ws_q;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;

  logic        pulse;
  logic        done;
  logic [31:0] mask;
  logic [31:0] base;
  logic [31:0] shnext;
  logic [31:0] first;

  function automatic logic [31:0] ins(
    input logic [31:0] b,
    input logic [4:0]  n,
    input logic        bit_i,
    input logic        lsb
  );
    logic [31:0] r;
    r = b;
    if (lsb) r[n] = bit_i;
    else     r = {b[30:0], bit_i};
    return r;
  endfunction

  assign pulse  = ws_i & ~ws_q;
  assign mask   = 32'hFFFF_FFFF >> (5'd31 - cfg_num_bits_i);
  // a new word always starts from a clean register
  assign base   = (bcnt_q == 5'd0) ? 32'd0 : shreg_q;
  assign shnext = ins(base, bcnt_q, sd_i, cfg_lsb_first_i);
  assign first  = ins(32'd0, 5'd0, sd_i, cfg_lsb_first_i);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovf_d   = 1'b0;
    done    = 1'b0;

    if (valid_q && data_ready_i) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        shreg_d = '0;
        bcnt_d  = '0;
        wcnt_d  = '0;
        if (cfg_en_i) state_d = SYNC;
      end
      SYNC, DATA: begin
        if (pulse) begin
          ferr_d  = (state_q == DATA);
          state_d = DATA;
          wcnt_d  = '0;
          bcnt_d  = cfg_dsp_delay_i ? 5'd0 : 5'd1;
          shreg_d = cfg_dsp_delay_i ? 32'd0 : first;
        end else if (state_q == DATA) begin
          shreg_d = shnext;
          bcnt_d  = bcnt_q + 5'd1;
          if (bcnt_q == cfg_num_bits_i) begin
            done   = 1'b1;
            bcnt_d = '0;
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == cfg_num_words_i) begin
              state_d = SYNC;
              wcnt_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!valid_q || data_ready_i) begin
        data_d  = shnext & mask;
        idx_d   = wcnt_q;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (!cfg_en_i) begin
      state_d = IDLE;
      shreg_d = '0;
      bcnt_d  = '0;
      wcnt_d  = '0;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ws_q    <= 1'b0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_i;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o       = data_q;
  assign word_idx_o   = idx_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_i2s_dsp_rx_frame_sync.sv
// Scoreboard bench for i2s_dsp_rx_frame_sync: directed frames,
// expected words queued at issue, checked on each handshake.
module tb_i2s_dsp_rx_frame_sync;

  logic        sck_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic [4:0]  cfg_num_bits_i;
  logic [2:0]  cfg_num_words_i;
  logic        cfg_dsp_delay_i;
  logic        cfg_lsb_first_i;
  logic        ws_i;
  logic        sd_i;
  logic [31:0] data_o;
  logic [2:0]  word_idx_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        frame_err_o;
  logic        overflow_o;

  i2s_dsp_rx_frame_sync dut (
    .sck_i(sck_i),
    .rstn_i(rstn_i),
    .cfg_en_i(cfg_en_i),
    .cfg_num_bits_i(cfg_num_bits_i),
    .cfg_num_words_i(cfg_num_words_i),
    .cfg_dsp_delay_i(cfg_dsp_delay_i),
    .cfg_lsb_first_i(cfg_lsb_first_i),
    .ws_i(ws_i),
    .sd_i(sd_i),
    .data_o(data_o),
    .word_idx_o(word_idx_o),
    .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o(overflow_o)
  );

  always #5 sck_i = ~sck_i;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovf_cnt  = 0;
  logic [34:0] sb[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: pops one expected word per accepted transfer
  always @(negedge sck_i) begin
    if (rstn_i) begin
      if (frame_err_o) ferr_cnt++;
      if (overflow_o)  ovf_cnt++;
      if (data_valid_o && data_ready_i) begin
        logic [34:0] e;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got 0x%0h idx %0d expected none",
                   data_o, word_idx_o);
        end else begin
          e = sb.pop_front();
          if ({word_idx_o, data_o} !== e) begin
            bad++;
            $display("FAIL word: got 0x%0h idx %0d expected 0x%0h idx %0d",
                     data_o, word_idx_o, e[31:0], e[34:32]);
          end
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic d);
    ws_i = w;
    sd_i = d;
    @(posedge sck_i);
    #1;
  endtask

  task automatic send_word(input logic [31:0] v, input int nb,
                           input logic lsb);
    for (int i = 0; i <= nb; i++)
      cyc(1'b0, lsb ? v[i] : v[nb-i]);
  endtask

  task automatic setcfg(input logic [4:0] nb, input logic [2:0] nw,
                        input logic dly, input logic lsb);
    cfg_en_i = 1'b0;
    cyc(1'b0, 1'b0);
    cfg_num_bits_i  = nb;
    cfg_num_words_i = nw;
    cfg_dsp_delay_i = dly;
    cfg_lsb_first_i = lsb;
    cfg_en_i = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] v, input logic [2:0] idx);
    sb.push_back({idx, v});
  endtask

  initial begin
    logic [31:0] v;
    rstn_i = 1'b0;
    cfg_en_i = 1'b0;
    cfg_num_bits_i = 5'd7;
    cfg_num_words_i = 3'd1;
    cfg_dsp_delay_i = 1'b1;
    cfg_lsb_first_i = 1'b0;
    ws_i = 1'b0;
    sd_i = 1'b0;
    data_ready_i = 1'b1;
    #12;
    check("rst_data", data_o, 32'd0);
    check("rst_idx", {29'd0, word_idx_o}, 32'd0);
    check("rst_flags", {29'd0, data_valid_o, frame_err_o, overflow_o}, 32'd0);
    rstn_i = 1'b1;
    @(posedge sck_i);
    #1;

    // mode A, 8b x 2, MSB first
    setcfg(5'd7, 3'd1, 1'b1, 1'b0);
    push(32'hA5, 3'd0);
    push(32'h3C, 3'd1);
    cyc(1'b1, 1'b0);
    send_word(32'hA5, 7, 1'b0);
    check("a_valid_lat", {31'd0, data_valid_o}, 32'd1);
    check("a_data_lat", data_o, 32'hA5);
    send_word(32'h3C, 7, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    check("a_no_err", ferr_cnt, 0);

    // mode B, 32b x 1, LSB first
    setcfg(5'd31, 3'd0, 1'b0, 1'b1);
    v = 32'h1234_5678;
    push(v, 3'd0);
    for (int i = 0; i < 32; i++) cyc(i == 0, v[i]);
    repeat (3) cyc(1'b0, 1'b0);

    // pulse after 5 of 16 bits
    setcfg(5'd15, 3'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    send_word(32'h001F, 4, 1'b0);
    cyc(1'b1, 1'b0);
    push(32'hBEEF, 3'd0);
    send_word(32'hBEEF, 15, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    check("err_pulses", ferr_cnt, 1);

    // overflow with ready low, 4 x 4 bits
    data_ready_i = 1'b0;
    setcfg(5'd3, 3'd3, 1'b1, 1'b0);
    push(32'h9, 3'd0);
    cyc(1'b1, 1'b0);
    send_word(32'h9, 3, 1'b0);
    send_word(32'h6, 3, 1'b0);
    send_word(32'h3, 3, 1'b0);
    send_word(32'hC, 3, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    check("ovf_pulses", ovf_cnt, 3);
    check("hold_data", data_o, 32'h9);
    check("hold_valid", {31'd0, data_valid_o}, 32'd1);
    data_ready_i = 1'b1;
    cyc(1'b0, 1'b0);
    check("drop_valid", {31'd0, data_valid_o}, 32'd0);

    // disable mid-word with a held word
    data_ready_i = 1'b0;
    setcfg(5'd7, 3'd1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    send_word(32'h55, 7, 1'b0);
    send_word(32'h5, 2, 1'b0);
    check("dis_pre_valid", {31'd0, data_valid_o}, 32'd1);
    cfg_en_i = 1'b0;
    cyc(1'b0, 1'b0);
    check("dis_valid", {31'd0, data_valid_o}, 32'd0);
    data_ready_i = 1'b1;
    cfg_en_i = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    push(32'h81, 3'd0);
    push(32'h7E, 3'd1);
    cyc(1'b1, 1'b0);
    send_word(32'h81, 7, 1'b0);
    send_word(32'h7E, 7, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    check("reen_no_err", ferr_cnt, 1);

    // async reset mid-frame
    data_ready_i = 1'b0;
    setcfg(5'd3, 3'd1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    send_word(32'hF, 3, 1'b0);
    send_word(32'h3, 1, 1'b0);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_data", data_o, 32'd0);
    check("arst_flags", {29'd0, data_valid_o, frame_err_o, overflow_o}, 32'd0);
    #3;
    rstn_i = 1'b1;
    @(posedge sck_i);
    #1;
    data_ready_i = 1'b1;
    cyc(1'b0, 1'b0);
    send_word(32'hA5, 7, 1'b0);
    check("arst_no_word", {31'd0, data_valid_o}, 32'd0);
    push(32'h5, 3'd0);
    push(32'hA, 3'd1);
    cyc(1'b1, 1'b0);
    send_word(32'h5, 3, 1'b0);
    send_word(32'hA, 3, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1'b0, 1'b0);
    check("sb_empty", sb.size(), 0);
    check("final_err", ferr_cnt, 1);
    check("final_ovf", ovf_cnt, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
